// File: rtl/tx_seq_pkg.sv
// Shared types and default sizing for the transmit frame sequencer.
package tx_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GUARD    = 2'd3
  } seqState_t;

  localparam int   DEF_PREAMBLE_BITS     = 32;
  localparam logic DEF_PREAMBLE_VALUE    = 1'b0;
  localparam int   DEF_FRAME_BITS        = 64;
  localparam int   DEF_GUARD_CYCLES      = 16;
  localparam int   DEF_UNDERFLOW_TIMEOUT = 255;
  localparam int   DEF_CNT_W             = 8;

endpackage

// File: rtl/bit_prefetch.sv
// Single-bit holding register in front of the modulator, fed either by a
// constant load or by a latency-1 FIFO read with at most one read in flight.
module bit_prefetch (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic loadConst,
  input  logic constValue,
  input  logic readPermit,
  input  logic fifoEmpty,
  input  logic fifoData,
  input  logic coderReady,
  output logic holdValid,
  output logic holdData,
  output logic readPending,
  output logic readStrobe,
  output logic consume
);

  assign consume    = coderReady & holdValid;
  assign readStrobe = readPermit & ~fifoEmpty & ~readPending & (~holdValid | consume);

  // A pending read always lands in an empty hold, so it cannot collide with a consume.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      holdValid   <= 1'b0;
      holdData    <= 1'b0;
      readPending <= 1'b0;
    end else begin
      readPending <= readStrobe;
      if (readPending) begin
        holdValid <= 1'b1;
        holdData  <= fifoData;
      end else if (loadConst) begin
        holdValid <= 1'b1;
        holdData  <= constValue;
      end else if (consume) begin
        holdValid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tx_frame_sequencer.sv
// Frame-level control: preamble, FIFO-paced payload, guard gap, underflow
// abort and status outputs for the test/control logic.
module tx_frame_sequencer
  import tx_seq_pkg::*;
#(
  parameter int   PREAMBLE_BITS     = DEF_PREAMBLE_BITS,
  parameter logic PREAMBLE_VALUE    = DEF_PREAMBLE_VALUE,
  parameter int   FRAME_BITS        = DEF_FRAME_BITS,
  parameter int   GUARD_CYCLES      = DEF_GUARD_CYCLES,
  parameter int   UNDERFLOW_TIMEOUT = DEF_UNDERFLOW_TIMEOUT,
  parameter int   CNT_W             = DEF_CNT_W
) (
  input  logic             inClock,
  input  logic             inReset,
  input  logic             inEnable,
  input  logic             inStart,
  input  logic             inFifoEmpty,
  input  logic             inFifoData,
  input  logic             inCoderReady,
  output logic             outFifoReadEnable,
  output logic             outCoderData,
  output logic             outCoderEmpty,
  output logic             outBusy,
  output logic             outDone,
  output logic             outUnderflow,
  output logic [CNT_W-1:0] outBitCount,
  output logic [1:0]       outState
);

  localparam logic [CNT_W-1:0] PRE_N      = CNT_W'(PREAMBLE_BITS);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_N    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] UF_LAST    = CNT_W'(UNDERFLOW_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  seqState_t        state;
  seqState_t        nextState;
  logic [CNT_W-1:0] bitCount;
  logic [CNT_W-1:0] issueCount;
  logic [CNT_W-1:0] starveCount;
  logic [CNT_W-1:0] guardCount;
  logic             underflowReg;
  logic             doneReg;

  logic holdValid;
  logic holdData;
  logic readPending;
  logic readStrobe;
  logic consume;

  logic startAccept;
  logic starved;
  logic underflowHit;
  logic preambleLast;
  logic payloadLast;
  logic guardLast;
  logic loadConst;
  logic readPermit;
  logic phaseChange;

  assign startAccept  = (state == IDLE) & inEnable & inStart;
  assign starved      = (state == PAYLOAD) & ~holdValid & ~readPending & inFifoEmpty;
  assign underflowHit = starved & (starveCount == UF_LAST);
  assign preambleLast = (state == PREAMBLE) & consume & (bitCount == PRE_LAST);
  assign payloadLast  = (state == PAYLOAD) & consume & (bitCount == FRAME_LAST);
  assign guardLast    = (state == GUARD) & (guardCount == GUARD_LAST);
  assign loadConst    = (state == PREAMBLE) & (~holdValid | consume) & (issueCount < PRE_N);
  assign readPermit   = (state == PAYLOAD) & (issueCount < FRAME_N) & ~underflowHit;
  assign phaseChange  = (nextState != state);

  bit_prefetch uPrefetch (
    .clock       (inClock),
    .reset       (inReset),
    .flush       (underflowHit),
    .loadConst   (loadConst),
    .constValue  (PREAMBLE_VALUE),
    .readPermit  (readPermit),
    .fifoEmpty   (inFifoEmpty),
    .fifoData    (inFifoData),
    .coderReady  (inCoderReady),
    .holdValid   (holdValid),
    .holdData    (holdData),
    .readPending (readPending),
    .readStrobe  (readStrobe),
    .consume     (consume)
  );

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (startAccept) nextState = PREAMBLE;
      PREAMBLE: if (preambleLast) nextState = PAYLOAD;
      PAYLOAD:  if (underflowHit || payloadLast) nextState = GUARD;
      GUARD:    if (guardLast) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Every phase boundary restarts the per-phase counters.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      bitCount     <= '0;
      issueCount   <= '0;
      starveCount  <= '0;
      guardCount   <= '0;
      underflowReg <= 1'b0;
      doneReg      <= 1'b0;
    end else begin
      doneReg <= guardLast;

      if (startAccept) begin
        underflowReg <= 1'b0;
      end else if (underflowHit) begin
        underflowReg <= 1'b1;
      end

      if (phaseChange) begin
        bitCount <= '0;
      end else if (consume) begin
        bitCount <= bitCount + ONE;
      end

      if (phaseChange) begin
        issueCount <= '0;
      end else if (loadConst || readStrobe) begin
        issueCount <= issueCount + ONE;
      end

      if (starved && !underflowHit) begin
        starveCount <= starveCount + ONE;
      end else begin
        starveCount <= '0;
      end

      if (state == GUARD && !guardLast) begin
        guardCount <= guardCount + ONE;
      end else begin
        guardCount <= '0;
      end
    end
  end

  assign outFifoReadEnable = readStrobe;
  assign outCoderData      = holdData;
  assign outCoderEmpty     = ~holdValid;
  assign outBusy           = (state != IDLE);
  assign outDone           = doneReg;
  assign outUnderflow      = underflowReg;
  assign outBitCount       = bitCount;
  assign outState          = state;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer: directed frames queue expected
// modulator bits, and a monitor checks every consumed bit plus frame status.
module tb_tx_frame_sequencer;

  logic       inClock = 1'b0;
  logic       inReset = 1'b1;
  logic       inEnable = 1'b0;
  logic       inStart = 1'b0;
  logic       inFifoEmpty = 1'b1;
  logic       inFifoData = 1'b0;
  logic       inCoderReady = 1'b0;
  logic       outFifoReadEnable;
  logic       outCoderData;
  logic       outCoderEmpty;
  logic       outBusy;
  logic       outDone;
  logic       outUnderflow;
  logic [7:0] outBitCount;
  logic [1:0] outState;

  bit fifoQ[$];
  bit expQ[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit readyHeld = 1'b0;

  int frameStrobes, frameConsumes, preConsumes, guardEmpty, frameDones;
  int starveRun, maxStarve, lastStrobe, gapBad, backToBack;
  bit prevStrobe = 1'b0;

  tx_frame_sequencer dut (
    .inClock           (inClock),
    .inReset           (inReset),
    .inEnable          (inEnable),
    .inStart           (inStart),
    .inFifoEmpty       (inFifoEmpty),
    .inFifoData        (inFifoData),
    .inCoderReady      (inCoderReady),
    .outFifoReadEnable (outFifoReadEnable),
    .outCoderData      (outCoderData),
    .outCoderEmpty     (outCoderEmpty),
    .outBusy           (outBusy),
    .outDone           (outDone),
    .outUnderflow      (outUnderflow),
    .outBitCount       (outBitCount),
    .outState          (outState)
  );

  always #5 inClock = ~inClock;

  // Modulator request pattern and FIFO empty flag, both settled well before the next edge.
  initial begin
    forever begin
      @(posedge inClock);
      cyc = cyc + 1;
      #1;
      inCoderReady = readyHeld || (cyc % 4 == 0);
      #1;
      inFifoEmpty = (fifoQ.size() == 0);
    end
  end

  always @(posedge inClock) begin
    if (outFifoReadEnable && fifoQ.size() > 0) inFifoData <= fifoQ.pop_front();
  end

  always @(negedge inClock) begin
    if (inReset) begin
      prevStrobe = 1'b0;
      starveRun  = 0;
    end else begin
      if (outFifoReadEnable) begin
        frameStrobes++;
        if (prevStrobe) backToBack++;
        if (readyHeld && outState == 2'd2 && lastStrobe >= 0 && cyc - lastStrobe != 2) gapBad++;
        lastStrobe = cyc;
      end
      if (outState == 2'd2 && outCoderEmpty && !prevStrobe && inFifoEmpty) begin
        starveRun++;
        if (starveRun > maxStarve) maxStarve = starveRun;
      end else begin
        starveRun = 0;
      end
      if (outState == 2'd3 && outCoderEmpty) guardEmpty++;
      if (outDone) frameDones++;
      if (inCoderReady && !outCoderEmpty) begin
        frameConsumes++;
        if (outState == 2'd1) preConsumes++;
        checks++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL extraBit: got bit %0b, expected no bit", outCoderData);
        end else begin
          bit e;
          e = expQ.pop_front();
          if (outCoderData === e) passes++;
          else $display("[TB] FAIL bitOrder#%0d: got %0b, expected %0b", frameConsumes, outCoderData, e);
        end
      end
      prevStrobe = outFifoReadEnable;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge inClock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic pushFifo(input logic [63:0] word, input int first, input int last);
    for (int i = first; i < last; i++) fifoQ.push_back(word[63-i]);
  endtask

  task automatic applyStimulus(input logic [63:0] word, input int nLoad, input int nExp, input bit held);
    fifoQ.delete();
    expQ.delete();
    frameStrobes = 0; frameConsumes = 0; preConsumes = 0; guardEmpty = 0; frameDones = 0;
    starveRun = 0; maxStarve = 0; lastStrobe = -1; gapBad = 0;
    readyHeld = held;
    for (int i = 0; i < 32; i++) expQ.push_back(1'b0);
    for (int i = 0; i < nExp; i++) expQ.push_back(word[63-i]);
    pushFifo(word, 0, nLoad);
    inEnable = 1'b1;
    inStart  = 1'b1;
    tick(1);
    inStart  = 1'b0;
  endtask

  task automatic checkFrameEnd(input string tag, input int expStrobes, input int expConsumes, input int expUnderflow);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge inClock);
      if (outDone) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, ".doneSeen"}, int'(seen), 1);
    checkOutput({tag, ".underflow"}, int'(outUnderflow), expUnderflow);
    checkOutput({tag, ".stateIdle"}, int'(outState), 0);
    tick(2);
    checkOutput({tag, ".donePulses"}, frameDones, 1);
    checkOutput({tag, ".readStrobes"}, frameStrobes, expStrobes);
    checkOutput({tag, ".consumes"}, frameConsumes, expConsumes);
    checkOutput({tag, ".preambleBits"}, preConsumes, 32);
    checkOutput({tag, ".guardEmpty"}, guardEmpty, 16);
    checkOutput({tag, ".bitsLeft"}, expQ.size(), 0);
  endtask

  initial begin
    backToBack = 0;
    applyReset();

    // Frame with sparse modulator requests
    applyStimulus(64'hA5A5_A5A5_A5A5_A5A5, 64, 64, 1'b0);
    checkOutput("t1.busy", int'(outBusy), 1);
    checkFrameEnd("t1", 64, 96, 0);

    // Modulator always ready: reads must be paced every second cycle
    applyStimulus(64'h0123_4567_89AB_CDEF, 64, 64, 1'b1);
    checkFrameEnd("t2", 64, 96, 0);
    checkOutput("t2.strobeSpacing", gapBad, 0);

    // FIFO runs dry after 20 payload bits, refills 100 cycles later
    applyStimulus(64'hF0E1_D2C3_B4A5_9687, 20, 64, 1'b0);
    for (int i = 0; i < 1000 && frameStrobes < 20; i++) tick(1);
    checkOutput("t3.strobesBeforeGap", frameStrobes, 20);
    tick(50);
    checkOutput("t3.gapState", int'(outState), 2);
    checkOutput("t3.gapCoderEmpty", int'(outCoderEmpty), 1);
    checkOutput("t3.gapBitCount", int'(outBitCount), 20);
    tick(50);
    pushFifo(64'hF0E1_D2C3_B4A5_9687, 20, 64);
    checkFrameEnd("t3", 64, 96, 0);

    // FIFO runs dry for good after 10 payload bits
    applyStimulus(64'h9C00_0000_0000_0000, 10, 10, 1'b0);
    checkFrameEnd("t4", 10, 42, 1);
    checkOutput("t4.starvedCycles", maxStarve, 255);

    // Next start clears underflow; a second start mid-payload and enable drop are ignored
    applyStimulus(64'h5A5A_0FF0_3CC3_9669, 64, 64, 1'b0);
    tick(2);
    checkOutput("t5.underflowCleared", int'(outUnderflow), 0);
    for (int i = 0; i < 1000 && outState != 2'd2; i++) tick(1);
    tick(3);
    inStart = 1'b1;
    tick(1);
    inStart = 1'b0;
    checkOutput("t5.startInPayload", int'(outState), 2);
    inEnable = 1'b0;
    checkFrameEnd("t5", 64, 96, 0);
    tick(40);
    checkOutput("t5.noExtraFrame", int'(outState), 0);
    checkOutput("t5.noExtraBits", frameConsumes, 96);
    inStart = 1'b1;
    tick(1);
    inStart = 1'b0;
    tick(2);
    checkOutput("t5.disabledStart", int'(outState), 0);
    checkOutput("t5.disabledBusy", int'(outBusy), 0);

    // Reset the cycle after a mid-payload read strobe
    applyStimulus(64'hC3A5_5A3C_F00F_1234, 64, 64, 1'b1);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge inClock);
        if (outFifoReadEnable && outState == 2'd2 && outBitCount >= 8'd5) begin
          hit = 1'b1;
          break;
        end
      end
      checkOutput("t6.strobeFound", int'(hit), 1);
    end
    @(posedge inClock);
    #1 inReset = 1'b1;
    @(posedge inClock);
    #1 inReset = 1'b0;
    checkOutput("t6.state", int'(outState), 0);
    checkOutput("t6.readEnable", int'(outFifoReadEnable), 0);
    checkOutput("t6.coderData", int'(outCoderData), 0);
    checkOutput("t6.coderEmpty", int'(outCoderEmpty), 1);
    checkOutput("t6.busy", int'(outBusy), 0);
    checkOutput("t6.done", int'(outDone), 0);
    checkOutput("t6.bitCount", int'(outBitCount), 0);
    tick(1);
    checkOutput("t6.coderEmptyHeld", int'(outCoderEmpty), 1);
    applyStimulus(64'h8421_1248_FEDC_0137, 64, 64, 1'b0);
    checkFrameEnd("t6", 64, 96, 0);

    checkOutput("all.backToBackStrobes", backToBack, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  task automatic applyReset();
    inReset = 1'b1;
    inEnable = 1'b0;
    inStart = 1'b0;
    tick(3);
    checkOutput("reset.readEnable", int'(outFifoReadEnable), 0);
    checkOutput("reset.coderEmpty", int'(outCoderEmpty), 1);
    inReset = 1'b0;
    tick(1);
    checkOutput("reset.state", int'(outState), 0);
    checkOutput("reset.coderData", int'(outCoderData), 0);
    checkOutput("reset.busy", int'(outBusy), 0);
    checkOutput("reset.done", int'(outDone), 0);
    checkOutput("reset.underflow", int'(outUnderflow), 0);
    checkOutput("reset.bitCount", int'(outBitCount), 0);
  endtask

endmodule

// File: doc/tx_frame_sequencer.md
Name: tx_frame_sequencer

Overview:
- Transmit-path controller between inFIFO (1-bit read side, read latency 1) and msk_modulator (i_data / i_empty / o_ready).
- On a start request it emits a fixed preamble, then exactly FRAME_BITS payload bits pulled from inFIFO, then a guard gap.
- Paces FIFO reads on coder demand, detects payload underflow, and reports frame status to the test/control logic.
- Replaces direct mux-driven read-enable / empty control in mission mode.

Parameters:
- PREAMBLE_BITS, 32: preamble length in bits.
- PREAMBLE_VALUE, 1'b0: constant bit value sent during preamble.
- FRAME_BITS, 64: payload bits per frame.
- GUARD_CYCLES, 16: idle clock cycles after the last payload bit is consumed.
- UNDERFLOW_TIMEOUT, 255: consecutive starved cycles in PAYLOAD before abort.
- CNT_W, 8: counter width; must satisfy 2^CNT_W > max(PREAMBLE_BITS, FRAME_BITS, GUARD_CYCLES, UNDERFLOW_TIMEOUT).

Ports:
- inClock  in  1  system clock
- inReset  in  1  synchronous, active-high reset
- inEnable  in  1  sequencer enable; when low, inStart is ignored
- inStart  in  1  frame request, sampled only in IDLE
- inFifoEmpty  in  1  inFIFO outEmpty
- inFifoData  in  1  inFIFO outData, valid the cycle after outFifoReadEnable
- inCoderReady  in  1  msk_modulator o_ready (bit request)
- outFifoReadEnable  out  1  one-cycle read strobe to inFIFO
- outCoderData  out  1  bit to msk_modulator i_data
- outCoderEmpty  out  1  to msk_modulator i_empty; high = no bit available
- outBusy  out  1  high in any state except IDLE
- outDone  out  1  one-cycle pulse on the GUARD->IDLE transition
- outUnderflow  out  1  sticky abort flag; cleared on next accepted start or reset
- outBitCount  out  CNT_W  bits consumed in the current phase
- outState  out  2  IDLE=0, PREAMBLE=1, PAYLOAD=2, GUARD=3

Behaviour:
- Reset (synchronous, inReset=1 at a rising edge): state IDLE; holding register empty; read-pending cleared; all counters 0. Outputs: outFifoReadEnable=0, outCoderData=0, outCoderEmpty=1, outBusy=0, outDone=0, outUnderflow=0.
- Reset mid-frame aborts immediately. An in-flight FIFO read is discarded. No outDone pulse.
- Holding register (hold_valid, hold_data) drives outCoderData=hold_data and outCoderEmpty=~hold_valid.
- Consume event = inCoderReady & hold_valid. On consume, hold_valid clears and outBitCount increments, unless the hold is refilled in the same cycle (preamble).
- IDLE -> PREAMBLE when inEnable & inStart. On this transition: clear outUnderflow, zero the counters.
- PREAMBLE:
  - hold is loaded with PREAMBLE_VALUE whenever it is empty or being consumed, while fewer than PREAMBLE_BITS bits have been loaded.
  - No FIFO reads occur.
  - After PREAMBLE_BITS consumes: go to PAYLOAD and reset outBitCount.
- PAYLOAD:
  - Issue outFifoReadEnable when all hold: ~inFifoEmpty; no read pending; (~hold_valid | consume); fewer than FRAME_BITS bits requested.
  - Maximum one outstanding read.
  - Next cycle, capture inFifoData into hold and set hold_valid.
  - Peak throughput is 1 bit per 2 cycles.
- Starvation counter: increments each PAYLOAD cycle with ~hold_valid & ~read_pending & inFifoEmpty; resets otherwise.
- Underflow: when the starvation counter reaches UNDERFLOW_TIMEOUT, set outUnderflow, clear hold, go to GUARD.
- Normal PAYLOAD exit: after FRAME_BITS consumes, go to GUARD.
- GUARD:
  - outCoderEmpty=1, no reads.
  - Count GUARD_CYCLES cycles, then go to IDLE with outDone=1 for one cycle.
- inStart while busy: ignored, no queuing. inEnable deasserted mid-frame: the frame completes normally.
- FIFO going empty then refilling before timeout: transmission resumes seamlessly and the bit count is preserved.
- inCoderReady while hold is empty: no consume and no error; outCoderEmpty=1 signals the gap.

Decomposition:
- Package tx_seq_pkg holds:
  - state enum (IDLE, PREAMBLE, PAYLOAD, GUARD), 2 bits;
  - default parameter constants.
- Sub-module bit_prefetch: holding register plus read-pending logic with the FIFO handshake. Inputs are a load-constant request and a read-permit; outputs are hold_valid, hold_data and read strobe.
- FSM and counters stay in the top module.

Test Plan:
1. Reset, FIFO preloaded with 64 bits of 0xA5 repeating; inCoderReady pulses every 4 cycles; inStart pulse.
   -> 32 zero bits, then 64 payload bits matching FIFO order, 64 read strobes, then outCoderEmpty=1 for 16 cycles, then outDone pulse, outUnderflow=0.
2. inCoderReady held at 1, FIFO always non-empty.
   -> in PAYLOAD, read strobes every 2nd cycle; no bit duplicated or dropped (bit index checker).
3. FIFO goes empty after 20 payload bits for 100 cycles, then refills.
   -> outCoderEmpty=1 during the gap; 64 bits total; outUnderflow=0.
4. FIFO goes empty after 10 payload bits indefinitely.
   -> exactly 255 starved cycles, then outUnderflow=1, GUARD, outDone. Next inStart clears outUnderflow.
5. inStart asserted in PAYLOAD, and inEnable=0 with inStart in IDLE.
   -> both ignored: outState unchanged, no extra frame.
6. inReset pulsed the cycle after a read strobe mid-PAYLOAD.
   -> next cycle all outputs at reset values, the captured bit is discarded, and a new start sends a full 32-bit preamble.
